// File: rtl/game_pkg.sv
// Shared game definitions: round state encoding, BCD digit width and score
// saturation point, also imported by the record block.
package game_pkg;

    localparam int BCD_W          = 4;
    localparam int SCORE_SAT_TENS = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DIE  = 2'd2,
        S_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score-record outputs of the score keeper.
// master = game-event / display side, slave = score_keeper.
interface score_keeper_if;
    import game_pkg::*;

    logic             start;
    logic             add_point;
    logic             add_bonus;
    logic             collide;
    logic [BCD_W-1:0] score_0;
    logic [BCD_W-1:0] score_1;
    logic             slime_die;
    state_t           game_state;

    modport master (
        output start, add_point, add_bonus, collide,
        input  score_0, score_1, slime_die, game_state
    );

    modport slave (
        input  start, add_point, add_bonus, collide,
        output score_0, score_1, slime_die, game_state
    );
endinterface

// File: rtl/score_keeper_bcd_sat_add.sv
// Two-digit BCD add of a 0..9 step with carry into the tens digit,
// saturating at MAX_TENS:0 (never wraps).
module bcd_sat_add
    import game_pkg::*;
#(
    parameter int MAX_TENS = SCORE_SAT_TENS
) (
    input  logic [BCD_W-1:0] ones_i,
    input  logic [BCD_W-1:0] tens_i,
    input  logic [BCD_W-1:0] step_i,
    output logic [BCD_W-1:0] ones_o,
    output logic [BCD_W-1:0] tens_o
);
    localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX_TENS);

    logic [BCD_W:0]   sum;
    logic [BCD_W-1:0] ones_c;
    logic [BCD_W-1:0] tens_c;
    logic             sat;

    always_comb begin
        sum = {1'b0, ones_i} + {1'b0, step_i};
        if (sum >= (BCD_W+1)'(10)) begin
            ones_c = BCD_W'(sum - (BCD_W+1)'(10));
            tens_c = tens_i + BCD_W'(1);
        end else begin
            ones_c = sum[BCD_W-1:0];
            tens_c = tens_i;
        end
        // Anything at or beyond MAX_TENS:0 collapses onto exactly MAX_TENS:0.
        sat = (tens_i >= MAX_T) || (tens_c > MAX_T) ||
              ((tens_c == MAX_T) && (ones_c != '0));
        ones_o = sat ? '0    : ones_c;
        tens_o = sat ? MAX_T : tens_c;
    end
endmodule

// File: rtl/score_keeper.sv
// Round state machine and live BCD score; strobes slime_die for the single
// S_DIE cycle so the record block can latch the final score.
module score_keeper
    import game_pkg::*;
#(
    parameter int BONUS_STEP = 5,
    parameter int MAX_TENS   = SCORE_SAT_TENS
) (
    input  logic               clk,
    input  logic               rst,
    score_keeper_if.slave      bus
);
    localparam logic [BCD_W-1:0] BONUS_W = BCD_W'(BONUS_STEP);

    state_t           state_q, state_d;
    logic [BCD_W-1:0] score0_q, score0_d;
    logic [BCD_W-1:0] score1_q, score1_d;
    logic             slime_die_q, slime_die_d;
    logic [BCD_W-1:0] step;
    logic [BCD_W-1:0] add_ones;
    logic [BCD_W-1:0] add_tens;

    assign step = (bus.add_point ? BCD_W'(1) : '0) + (bus.add_bonus ? BONUS_W : '0);

    bcd_sat_add #(.MAX_TENS(MAX_TENS)) u_add (
        .ones_i (score0_q),
        .tens_i (score1_q),
        .step_i (step),
        .ones_o (add_ones),
        .tens_o (add_tens)
    );

    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d  = S_PLAY;
                    score0_d = '0;
                    score1_d = '0;
                end
            end
            S_PLAY: begin
                // Collision wins: points arriving with it are dropped.
                if (bus.collide) begin
                    state_d = S_DIE;
                end else begin
                    score0_d = add_ones;
                    score1_d = add_tens;
                end
            end
            S_DIE:   state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
        slime_die_d = (state_d == S_DIE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            score0_q    <= '0;
            score1_q    <= '0;
            slime_die_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            slime_die_q <= slime_die_d;
        end
    end

    assign bus.score_0    = score0_q;
    assign bus.score_1    = score1_q;
    assign bus.slime_die  = slime_die_q;
    assign bus.game_state = state_q;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal-score model pushes the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_score_keeper;
    import game_pkg::*;

    localparam int BONUS = 5;

    typedef struct {
        int st;
        int s1;
        int s0;
        int die;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    score_keeper_if bus();

    score_keeper #(.BONUS_STEP(BONUS), .MAX_TENS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_state  = 0;
    int   m_score  = 0;
    int   die_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model, compare after the edge.
    task automatic cycle(input bit st, input bit ap, input bit ab, input bit col, input string tag);
        exp_t e;
        int   nxt_state;
        nxt_state = m_state;
        bus.start = st; bus.add_point = ap; bus.add_bonus = ab; bus.collide = col;
        case (m_state)
            0, 3: if (st) begin nxt_state = 1; m_score = 0; end
            1: begin
                if (col) nxt_state = 2;
                else begin
                    m_score = m_score + (ap ? 1 : 0) + (ab ? BONUS : 0);
                    if (m_score > 100) m_score = 100;
                end
            end
            default: nxt_state = 3;
        endcase
        m_state = nxt_state;
        e.st = m_state; e.s1 = m_score / 10; e.s0 = m_score % 10; e.die = (m_state == 2) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (bus.slime_die) die_seen++;
        $display("cyc %-10s st=%0d ap=%0d ab=%0d col=%0d -> state=%0d score=%0d%0d die=%0d",
                 tag, st, ap, ab, col, bus.game_state, bus.score_1, bus.score_0, bus.slime_die);
        check({tag, ".state"}, int'(bus.game_state), e.st);
        check({tag, ".tens"},  int'(bus.score_1),    e.s1);
        check({tag, ".ones"},  int'(bus.score_0),    e.s0);
        check({tag, ".die"},   int'(bus.slime_die),  e.die);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        bus.start = 0; bus.add_point = 0; bus.add_bonus = 0; bus.collide = 0;
        rst = 1'b1;
        #2;
        m_state = 0; m_score = 0;
        $display("rst %-10s state=%0d score=%0d%0d die=%0d",
                 tag, bus.game_state, bus.score_1, bus.score_0, bus.slime_die);
        check({tag, ".state"}, int'(bus.game_state), 0);
        check({tag, ".tens"},  int'(bus.score_1),    0);
        check({tag, ".ones"},  int'(bus.score_0),    0);
        check({tag, ".die"},   int'(bus.slime_die),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.add_point = 0; bus.add_bonus = 0; bus.collide = 0;
        #1;
        do_reset("por");

        // Reach 37 then reset mid-round.
        cycle(1, 0, 0, 0, "start");
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, "bonus");
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, "point");
        check("score37", int'(bus.score_1) * 10 + int'(bus.score_0), 37);
        do_reset("midrst");
        check("no_die_after_rst", die_seen, 0);
        cycle(0, 0, 0, 0, "idle");

        // Carry.
        cycle(1, 0, 0, 0, "start");
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, "to08");
        cycle(0, 1, 0, 0, "to09");
        cycle(0, 1, 0, 0, "to10");
        cycle(0, 0, 1, 0, "to15");
        cycle(0, 1, 1, 0, "to21");

        // Saturation from 97.
        for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, "climb");
        cycle(0, 1, 0, 0, "to97");
        cycle(0, 0, 1, 0, "sat100");
        cycle(0, 1, 0, 0, "hold100");
        cycle(0, 1, 1, 0, "hold100b");
        cycle(0, 0, 0, 1, "die100");
        cycle(0, 0, 0, 0, "over100");

        // Collision priority at 42.
        cycle(1, 0, 0, 0, "restart");
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, "to40");
        cycle(0, 1, 0, 0, "to41");
        cycle(0, 1, 0, 0, "to42");
        cycle(0, 1, 0, 1, "colpt");
        cycle(0, 0, 0, 0, "over42");

        // Held collide, start during S_DIE ignored, points ignored in S_OVER.
        cycle(1, 0, 0, 0, "restart");
        cycle(0, 1, 0, 0, "to01");
        die_seen = 0;
        for (int i = 0; i < 10; i++)
            cycle((m_state == 2) ? 1'b1 : 1'b0, (i > 2) ? 1'b1 : 1'b0, (i > 4) ? 1'b1 : 1'b0, 1, "heldcol");
        check("die_pulses", die_seen, 1);
        cycle(1, 0, 0, 1, "ovstart");
        cycle(0, 0, 0, 0, "play00");

        // Idle filtering.
        do_reset("rst2");
        die_seen = 0;
        cycle(0, 1, 0, 0, "idle_ap");
        cycle(0, 0, 1, 0, "idle_ab");
        cycle(0, 1, 1, 1, "idle_all");
        check("idle_no_die", die_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Source side of the score-record interface: produces the live two-digit BCD score (score_0 = ones, score_1 = tens) and the one-cycle slime_die strobe.
- The record block samples both on that strobe to update its last and highest values.
- Sits between the game-event logic (point, bonus, collision, start key) and the record block and 7-segment display path.
- Owns the round state machine and saturating BCD score arithmetic.

Parameters:
- BONUS_STEP, 5, points added by one add_bonus pulse; legal range 1..8.
- MAX_TENS, 10, saturation value of score_1; score 100 is encoded score_1=10, score_0=0. The record block clamps this encoding to 99.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse from debounced start key
- add_point  input  1  one-cycle pulse, +1 point
- add_bonus  input  1  one-cycle pulse, +BONUS_STEP points
- collide  input  1  level or pulse, slime hit obstacle
- score_0  output  4  live ones digit, BCD 0..9
- score_1  output  4  live tens digit, 0..10
- slime_die  output  1  one-cycle strobe, round ended
- game_state  output  2  current FSM state, for the display mux

Behaviour:
- Reset: asynchronous, active-high, applied on the rising edge of rst independent of clk.
- Reset values: state=S_IDLE, score_0=0, score_1=0, slime_die=0, game_state=S_IDLE.
- Reset mid-round: no slime_die pulse is issued.
- All other updates occur on posedge clk. All outputs are registered (Moore).
- FSM states: S_IDLE=0, S_PLAY=1, S_DIE=2, S_OVER=3.
- S_IDLE:
  - start -> S_PLAY; score cleared to 00 on the same edge.
  - All other inputs are ignored.
- S_PLAY:
  - collide=1 -> S_DIE. Score is frozen; any add_point/add_bonus in that same cycle is discarded (collide wins).
  - Otherwise the score updates by step = add_point*1 + add_bonus*BONUS_STEP (0..9). A step of 0 holds the score.
  - start is ignored in S_PLAY.
- BCD arithmetic:
  - s = score_0 + step.
  - If s>=10: score_0 <= s-10 and score_1 increments; else score_0 <= s.
  - Saturation: if the result would exceed 100, or score_1 is already MAX_TENS, the score becomes and stays score_1=10, score_0=0.
  - Examples: 98+5 -> 100. 99+1 -> 100. 100+any -> 100.
  - No wrap to 00, ever.
- S_DIE:
  - Lasts exactly one cycle; slime_die=1 only in this state.
  - Score is held stable throughout, so the record block latches the final value.
  - Unconditional transition -> S_OVER.
- S_OVER:
  - Score held for display; slime_die=0.
  - start -> S_PLAY with score cleared to 00.
  - collide and points are ignored.
- slime_die:
  - Asserts one cycle after the collide sample.
  - Never asserts for two consecutive cycles.
  - Never asserts outside S_DIE.
- A collide held high across S_DIE/S_OVER produces no second strobe.
- start arriving in S_DIE is ignored; it is not queued.
- game_state equals the state register.

Decomposition:
- Shared package game_pkg:
  - state enum (S_IDLE, S_PLAY, S_DIE, S_OVER), 2 bits.
  - BCD digit width constant (4).
  - SCORE_SAT_TENS=10.
  - The record block imports the same saturation constant.
- One natural sub-module, bcd_sat_add:
  - combinational; inputs ones, tens, step 0..9.
  - outputs next ones/tens with carry and saturation to 100.
  - instantiated once; unit-testable alone.

Test Plan:
- Reset and start: rst mid-S_PLAY with score 37 -> immediately score 00, S_IDLE, no slime_die. Then start -> S_PLAY next cycle, score 00.
- Carry: from 08, add_point x2 -> 09, then 10. Then add_bonus (BONUS_STEP=5) -> 15. add_point+add_bonus same cycle from 15 -> 21.
- Saturation: from 97, add_bonus -> score_1=10, score_0=0. Further add_point -> unchanged 100. collide -> slime_die with 100 on score lines.
- Collision priority: score 42, add_point and collide same cycle -> next cycle S_DIE, slime_die=1, score 42. Following cycle S_OVER, slime_die=0, score 42.
- Held collide: collide high for 10 cycles from S_PLAY -> exactly one slime_die pulse. start in S_OVER -> S_PLAY, score 00.
- Idle filtering: add_point/add_bonus/collide in S_IDLE and S_OVER -> score and state unchanged, slime_die stays 0.
